// File: rtl/nes_video_pkg.sv
// nes_video_pkg: shared NES/HDMI video geometry and scanline write-FSM states
package nes_video_pkg;
  localparam int NES_W = 256;
  localparam int NES_H = 240;
  localparam int HDMI_W = 640;
  localparam int HDMI_H = 480;
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_FILL} wstate_t;
endpackage

// File: rtl/scanline_sched_if.sv
// scanline_sched_if: HDMI read side and PPU line-request/pixel side of the scheduler
interface scanline_sched_if;
  logic        i_rd;
  logic        i_newline;
  logic        i_newframe;
  logic [23:0] o_pixel;
  logic        o_line_req;
  logic [7:0]  o_line_num;
  logic        i_px_valid;
  logic [23:0] i_px_data;
  logic        o_underrun;
  modport master (
    output i_rd, i_newline, i_newframe, i_px_valid, i_px_data,
    input  o_pixel, o_line_req, o_line_num, o_underrun
  );
  modport slave (
    input  i_rd, i_newline, i_newframe, i_px_valid, i_px_data,
    output o_pixel, o_line_req, o_line_num, o_underrun
  );
endinterface

// File: rtl/scanline_sched_line_buf.sv
// line_buf: two-bank NES line buffer, synchronous write, asynchronous read
module line_buf
  import nes_video_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic        wbank,
  input  logic [7:0]  waddr,
  input  logic [23:0] wdata,
  input  logic        rbank,
  input  logic [7:0]  raddr,
  output logic [23:0] rdata
);
  logic [23:0] mem [2][NES_W];
  always_ff @(posedge clk)
    if (we) mem[wbank][waddr] <= wdata;
  assign rdata = mem[rbank][raddr];
endmodule

// File: rtl/scanline_sched.sv
// scanline_sched: line-doubling scheduler, PPU 256x240 into a two-bank buffer, served as 640x480 HDMI
module scanline_sched
  import nes_video_pkg::*;
#(
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter int          H_OFFSET   = 64
) (
  input  logic clk,
  input  logic i_reset_n,
  scanline_sched_if.slave bus
);
  logic [9:0]  x;
  logic [8:0]  y, y_nxt;
  logic        rd_bank, frame_pend, swap, acc, last;
  logic [7:0]  wcnt, half, req_num, raddr;
  logic [23:0] rd_data;
  wstate_t     state;
  // a pending newframe makes the next newline restart at row 0
  assign y_nxt = (frame_pend | bus.i_newframe) ? 9'd0 : (y == 9'(HDMI_H - 1)) ? y : y + 9'd1;
  assign swap = bus.i_newline & ~y_nxt[0];
  assign half = y_nxt[8:1];
  assign req_num = (half < 8'(NES_H - 1)) ? half + 8'd1 : 8'd0;
  assign acc = bus.o_line_req & bus.i_px_valid;
  assign last = acc & (wcnt == 8'(NES_W - 1));
  assign raddr = 8'((x - 10'(H_OFFSET)) >> 1);
  assign bus.o_pixel = (x >= 10'(H_OFFSET) && x < 10'(H_OFFSET + 2 * NES_W)) ? rd_data : BORDER_RGB;
  line_buf u_buf (
    .clk(clk), .we(acc), .wbank(~rd_bank), .waddr(wcnt), .wdata(bus.i_px_data),
    .rbank(rd_bank), .raddr(raddr), .rdata(rd_data)
  );
  always_ff @(posedge clk or negedge i_reset_n)
    if (!i_reset_n) begin
      x <= '0;
      y <= '0;
      frame_pend <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      x <= bus.i_newline ? 10'd0 : (bus.i_rd && x != 10'(HDMI_W - 1)) ? x + 10'd1 : x;
      y <= bus.i_newline ? y_nxt : y;
      frame_pend <= ~bus.i_newline & (frame_pend | bus.i_newframe);
      rd_bank <= rd_bank ^ swap;
    end
  // a swap replaces any outstanding request; finishing on the swap edge is not an underrun
  always_ff @(posedge clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= W_INIT;
      bus.o_line_req <= 1'b0;
      bus.o_line_num <= '0;
      bus.o_underrun <= 1'b0;
      wcnt <= '0;
    end else if (swap) begin
      bus.o_underrun <= bus.o_underrun | (state == W_FILL && !last);
      state <= W_FILL;
      bus.o_line_req <= 1'b1;
      bus.o_line_num <= req_num;
      wcnt <= '0;
    end else if (acc) begin
      wcnt <= wcnt + 8'd1;
      state <= last ? W_IDLE : state;
      bus.o_line_req <= ~last;
    end else if (state == W_INIT) begin
      state <= W_FILL;
      bus.o_line_req <= 1'b1;
      bus.o_line_num <= '0;
    end
endmodule

// File: tb/tb_scanline_sched.sv
// tb_scanline_sched: directed sequence with random pixel data against an array model of the line banks
module tb_scanline_sched;
  localparam logic [23:0] BRD = 24'hA55AC3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  scanline_sched_if bus();
  scanline_sched #(.BORDER_RGB(BRD), .H_OFFSET(64)) dut (.clk(clk), .i_reset_n(rst_n), .bus(bus.slave));
  int errs = 0, checks = 0;
  logic [23:0] mb [2][256];
  bit mk [2][256];
  int mx, my, mrd, mwcnt, mnum;
  bit mreq, mund, pend, boot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    mx = 0; my = 0; mrd = 0; mwcnt = 0; mnum = 0;
    mreq = 0; mund = 0; pend = 0; boot = 1;
  endtask

  task automatic cyc(input bit rd, input bit nl, input bit nf, input bit pv, input logic [23:0] pd);
    bit done, sw;
    bus.i_rd = rd; bus.i_newline = nl; bus.i_newframe = nf; bus.i_px_valid = pv; bus.i_px_data = pd;
    done = 0;
    sw = 0;
    if (mreq && pv) begin
      mb[1 - mrd][mwcnt] = pd;
      mk[1 - mrd][mwcnt] = 1;
      mwcnt++;
      done = (mwcnt == 256);
    end
    if (nl) mx = 0;
    else if (rd && mx < 639) mx++;
    if (nl) begin
      my = (pend || nf) ? 0 : (my < 479 ? my + 1 : 479);
      sw = (my % 2 == 0);
    end
    pend = !nl && (pend || nf);
    if (sw) begin
      if (mreq && !done) mund = 1;
      mrd = 1 - mrd;
      mreq = 1;
      mnum = (my / 2 < 239) ? my / 2 + 1 : 0;
      mwcnt = 0;
    end else if (done) mreq = 0;
    else if (boot) begin
      mreq = 1;
      mnum = 0;
      mwcnt = 0;
    end
    boot = 0;
    @(posedge clk);
    #1;
    bus.i_rd = 0; bus.i_newline = 0; bus.i_newframe = 0; bus.i_px_valid = 0; bus.i_px_data = '0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".req"}, 32'(bus.o_line_req), 32'(mreq));
    chk({tag, ".num"}, 32'(bus.o_line_num), 32'(mnum));
    chk({tag, ".und"}, 32'(bus.o_underrun), 32'(mund));
  endtask

  task automatic chk_pix(input string tag);
    if (mx >= 64 && mx < 576) begin
      if (mk[mrd][(mx - 64) / 2]) chk(tag, 32'(bus.o_pixel), 32'(mb[mrd][(mx - 64) / 2]));
    end else chk(tag, 32'(bus.o_pixel), 32'(BRD));
  endtask

  task automatic scan_row(input string tag);
    for (int c = 0; c < 640; c++) begin
      chk_pix(tag);
      cyc(1, 0, 0, 0, 0);
    end
  endtask

  task automatic fill(input int n, input bit idx, input logic [23:0] base);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 24'($urandom));
      cyc(0, 0, 0, 1, idx ? base ^ 24'(i) : 24'($urandom));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_rd = 0; bus.i_newline = 0; bus.i_newframe = 0; bus.i_px_valid = 0; bus.i_px_data = '0;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req", 32'(bus.o_line_req), 0);
    chk("rst.num", 32'(bus.o_line_num), 0);
    chk("rst.und", 32'(bus.o_underrun), 0);
    chk("rst.pix", 32'(bus.o_pixel), 32'(BRD));
    rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    chk_state("boot");
    chk("boot.req1", 32'(bus.o_line_req), 1);
    fill(256, 1, 24'h0);
    chk_state("fill0");
    chk("fill0.reqlow", 32'(bus.o_line_req), 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk_state("row0");
    chk("row0.num1", 32'(bus.o_line_num), 1);
    for (int c = 0; c < 640; c++) begin
      chk_pix("row0.pix");
      if (c == 63 || c == 576) chk("row0.border", 32'(bus.o_pixel), 32'(BRD));
      if (c == 64 || c == 65) chk("row0.first", 32'(bus.o_pixel), 0);
      if (c == 575) chk("row0.last", 32'(bus.o_pixel), 255);
      cyc(1, 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0);
    chk_pix("row0.sat");
    fill(100, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk_state("row1");
    scan_row("row1.pix");
    cyc(0, 1, 0, 0, 0);
    chk_state("row2");
    chk("row2.und", 32'(bus.o_underrun), 1);
    chk("row2.num", 32'(bus.o_line_num), 2);
    scan_row("row2.pix");
    while (my < 476) begin
      fill($urandom_range(0, 40), 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk_state("mid");
    end
    fill(256, 0, 0);
    chk_state("l239");
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk_state("y478");
    chk("y478.num0", 32'(bus.o_line_num), 0);
    fill(256, 0, 0);
    chk_state("pref");
    cyc(0, 1, 0, 0, 0);
    chk_state("y479");
    cyc(0, 1, 0, 0, 0);
    chk_state("ysat");
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk_state("frame2");
    scan_row("frame2.pix");
    fill(100, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst.req", 32'(bus.o_line_req), 0);
    chk("arst.num", 32'(bus.o_line_num), 0);
    chk("arst.und", 32'(bus.o_underrun), 0);
    mreset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    chk_state("reboot");
    fill(256, 1, 24'h5A0000);
    chk_state("refill");
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk_state("rerow0");
    scan_row("rerow0.pix");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
